// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared FSM states, default widths and timeout-counter sizing for sdram_host_arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, SETTLE} arb_state_t;
  localparam int DEF_NUM_CLIENTS = 3;
  localparam int DEF_ADDR_WIDTH = 24;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_RD_TIMEOUT = 1023;
  function automatic int tmo_width(input int rd_timeout);
    return $clog2(rd_timeout + 1);
  endfunction
endpackage

// File: rtl/sdram_host_arbiter_rr_picker.sv
// rr_picker: round-robin one-hot pick after the last granted index; SDRAM_ARB_CLIENT0_PRIORITY_EN lets client 0 override
module rr_picker #(
  parameter int N = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          valid
);
  int best;
  // nearest requester after last wins, wrapping through the vector
  always_comb begin
    idx = '0;
    best = N;
    for (int c = 0; c < N; c++)
      if (req[c] && (c - int'(last) + N - 1) % N < best) begin
        best = (c - int'(last) + N - 1) % N;
        idx = IW'(c);
      end
`ifdef SDRAM_ARB_CLIENT0_PRIORITY_EN
    if (req[0]) idx = '0;
`endif
    valid = |req;
    pick = '0;
    pick[idx] = valid;
  end
endmodule

// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: shares the sdram_controller host port among clients; SDRAM_ARB_CLIENT0_PRIORITY_EN gives client 0 priority
module sdram_host_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int RD_TIMEOUT  = DEF_RD_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            cl_req,
  input  logic [NUM_CLIENTS-1:0]            cl_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]            cl_gnt,
  output logic [NUM_CLIENTS-1:0]            cl_rvalid,
  output logic [DATA_WIDTH-1:0]             cl_rdata,
  output logic                              cl_rerr,
  output logic [ADDR_WIDTH-1:0]             ctrl_wr_addr,
  output logic [ADDR_WIDTH-1:0]             ctrl_rd_addr,
  output logic [DATA_WIDTH-1:0]             ctrl_wr_data,
  output logic                              ctrl_wr_enable,
  output logic                              ctrl_rd_enable,
  input  logic [DATA_WIDTH-1:0]             ctrl_rd_data,
  input  logic                              ctrl_rd_ready,
  input  logic                              ctrl_busy,
  output logic                              arb_timeout
);
  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TW = tmo_width(RD_TIMEOUT);
  arb_state_t state, state_d;
  logic [IW-1:0] last_grant, pick_idx;
  logic [NUM_CLIENTS-1:0] pick, owner;
  logic pick_valid, pick_we, upd_last, accept, rd_done, rd_tmo;
  logic [TW-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  rr_picker #(.N(NUM_CLIENTS), .IW(IW)) u_pick (
    .req(cl_req),
    .last(last_grant),
    .pick(pick),
    .idx(pick_idx),
    .valid(pick_valid)
  );

  assign pick_we = cl_we[pick_idx];
`ifdef SDRAM_ARB_CLIENT0_PRIORITY_EN
  assign upd_last = pick_idx != '0;
`else
  assign upd_last = 1'b1;
`endif
  assign ctrl_wr_enable = state == WRITE;
  assign ctrl_rd_enable = state == READ;
  assign ctrl_wr_addr = addr_q;
  assign ctrl_rd_addr = addr_q;
  assign ctrl_wr_data = wdata_q;

  // arbitration decision, read completion/abort and next state
  always_comb begin
    accept = state == IDLE && pick_valid && !ctrl_busy;
    rd_done = state == READ && ctrl_rd_ready;
    rd_tmo = state == READ && !ctrl_rd_ready && wait_cnt == TW'(RD_TIMEOUT - 1);
    state_d = accept ? (pick_we ? WRITE : READ)
            : (state == WRITE || rd_done || rd_tmo) ? SETTLE
            : state == SETTLE ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;

  // request latching, client pulses, read data and the sticky timeout flag
  always_ff @(posedge clk)
    if (rst) begin
      last_grant <= IW'(NUM_CLIENTS - 1);
      owner <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wait_cnt <= '0;
      cl_gnt <= '0;
      cl_rvalid <= '0;
      cl_rdata <= '0;
      cl_rerr <= 1'b0;
      arb_timeout <= 1'b0;
    end else begin
      cl_gnt <= accept ? pick : '0;
      cl_rvalid <= (rd_done || rd_tmo) ? owner : '0;
      cl_rerr <= rd_tmo;
      cl_rdata <= rd_done ? ctrl_rd_data : rd_tmo ? '0 : cl_rdata;
      arb_timeout <= arb_timeout | rd_tmo;
      wait_cnt <= accept ? '0 : state == READ ? wait_cnt + 1'b1 : wait_cnt;
      if (accept) begin
        owner <= pick;
        addr_q <= ADDR_WIDTH'(cl_addr >> (ADDR_WIDTH * int'(pick_idx)));
        wdata_q <= DATA_WIDTH'(cl_wdata >> (DATA_WIDTH * int'(pick_idx)));
        if (upd_last) last_grant <= pick_idx;
      end
    end
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter: scoreboard bench for sdram_host_arbiter with a small controller read model
module tb_sdram_host_arbiter;
  localparam int N = 3, AW = 24, DW = 16, TMO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] cl_req = '0, cl_we = '0;
  logic [N*AW-1:0] cl_addr = '0;
  logic [N*DW-1:0] cl_wdata = '0;
  logic [N-1:0] cl_gnt, cl_rvalid;
  logic [DW-1:0] cl_rdata;
  logic cl_rerr;
  logic [AW-1:0] ctrl_wr_addr, ctrl_rd_addr;
  logic [DW-1:0] ctrl_wr_data;
  logic ctrl_wr_enable, ctrl_rd_enable;
  logic [DW-1:0] ctrl_rd_data = '0;
  logic ctrl_rd_ready = 1'b0, ctrl_busy = 1'b0;
  logic arb_timeout;
  int tests = 0, fails = 0;
  int rd_lat = 0, rd_cnt = 0, rd_run = 0, last_run = 0;
  logic rdy_prev = 1'b0;
  typedef struct {int kind; logic [N-1:0] oh; logic [AW-1:0] a; logic [DW-1:0] d; logic e;} exp_t;
  exp_t exp_q[$];

  sdram_host_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cl_req(cl_req), .cl_we(cl_we), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_gnt(cl_gnt), .cl_rvalid(cl_rvalid), .cl_rdata(cl_rdata), .cl_rerr(cl_rerr),
    .ctrl_wr_addr(ctrl_wr_addr), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_wr_data(ctrl_wr_data),
    .ctrl_wr_enable(ctrl_wr_enable), .ctrl_rd_enable(ctrl_rd_enable), .ctrl_rd_data(ctrl_rd_data),
    .ctrl_rd_ready(ctrl_rd_ready), .ctrl_busy(ctrl_busy), .arb_timeout(arb_timeout)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input int k, input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.kind = k;
    x.oh = (k == 1) ? '0 : N'(1) << c;
    x.a = a;
    x.d = d;
    x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic got(input int k, input logic [N-1:0] oh, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    exp_t x;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_evt: got kind=%0d oh=%b a=%0h d=%0h e=%b want none", k, oh, a, d, e);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != k || x.oh !== oh || x.a !== a || x.d !== d || x.e !== e) begin
        fails++;
        $display("FAIL evt: got kind=%0d oh=%b a=%0h d=%0h e=%b want kind=%0d oh=%b a=%0h d=%0h e=%b",
                 k, oh, a, d, e, x.kind, x.oh, x.a, x.d, x.e);
      end
    end
  endtask

  // monitor: every grant, write strobe and read return is checked against the scoreboard
  always @(negedge clk) begin
    if (cl_gnt != '0) got(0, cl_gnt, '0, '0, 1'b0);
    if (ctrl_wr_enable) got(1, '0, ctrl_wr_addr, ctrl_wr_data, 1'b0);
    if (cl_rvalid != '0) begin
      got(2, cl_rvalid, '0, cl_rdata, cl_rerr);
      if (!cl_rerr) chk("rvalid_after_ready", 64'(rdy_prev), 64'd1);
    end
    if (ctrl_rd_enable) rd_run++;
    else if (rd_run > 0) begin
      last_run = rd_run;
      rd_run = 0;
    end
  end

  always @(posedge clk) rdy_prev <= ctrl_rd_ready;

  // controller model: ready in the rd_lat-th enabled cycle; rd_lat=0 never answers
  always @(negedge clk)
    if (ctrl_rd_enable) begin
      rd_cnt++;
      ctrl_rd_ready = (rd_cnt == rd_lat);
    end else begin
      rd_cnt = 0;
      ctrl_rd_ready = 1'b0;
    end

  task automatic wait_gnts(input int n, output int cyc);
    int seen = 0;
    cyc = 0;
    for (int t = 0; t < 400 && seen < n; t++) begin
      @(negedge clk);
      cyc++;
      if (cl_gnt != '0) seen++;
    end
    if (seen < n) begin
      tests++;
      fails++;
      $display("FAIL wait_gnt: got %0d grants want %0d", seen, n);
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic bad;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(cl_gnt), 0);
    chk("rst_rvalid", 64'(cl_rvalid), 0);
    chk("rst_rdata", 64'(cl_rdata), 0);
    chk("rst_rerr", 64'(cl_rerr), 0);
    chk("rst_wr_en", 64'(ctrl_wr_enable), 0);
    chk("rst_rd_en", 64'(ctrl_rd_enable), 0);
    chk("rst_timeout", 64'(arb_timeout), 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      cl_addr[i*AW +: AW] = AW'(24'h100 + i);
      cl_wdata[i*DW +: DW] = DW'(16'ha000 + i);
    end
    for (int k = 0; k < 6; k++) begin
`ifdef SDRAM_ARB_CLIENT0_PRIORITY_EN
      push(0, 0, '0, '0, 1'b0);
      push(1, 0, AW'(24'h100), DW'(16'ha000), 1'b0);
`else
      push(0, k % 3, '0, '0, 1'b0);
      push(1, 0, AW'(24'h100 + k % 3), DW'(16'ha000 + k % 3), 1'b0);
`endif
    end
    cl_we = '1;
    cl_req = '1;
    wait_gnts(6, cyc);
    cl_req = '0;
    wait_done();
    cl_we = 3'b010;
    cl_addr[1*AW +: AW] = 24'h5;
    cl_wdata[1*DW +: DW] = 16'hdeaf;
    push(0, 1, '0, '0, 1'b0);
    push(1, 0, 24'h5, 16'hdeaf, 1'b0);
    cl_req = 3'b010;
    wait_gnts(1, cyc);
    chk("wr_latency", 64'(cyc), 1);
    chk("wr_en_with_gnt", 64'(ctrl_wr_enable), 1);
    cl_req = '0;
    wait_done();
    cl_we = '0;
    cl_addr[2*AW +: AW] = 24'h5;
    ctrl_rd_data = 16'hdeaf;
    rd_lat = 6;
    push(0, 2, '0, '0, 1'b0);
    push(2, 2, '0, 16'hdeaf, 1'b0);
    cl_req = 3'b100;
    wait_gnts(1, cyc);
    chk("rd_addr", 64'(ctrl_rd_addr), 64'h5);
    chk("rd_en_with_gnt", 64'(ctrl_rd_enable), 1);
    cl_req = '0;
    wait_done();
    chk("rd_en_len", 64'(last_run), 6);
    chk("rdata_hold", 64'(cl_rdata), 64'hdeaf);
    ctrl_busy = 1'b1;
    cl_we = 3'b001;
    cl_addr[0*AW +: AW] = 24'h77;
    cl_wdata[0*DW +: DW] = 16'h1234;
    cl_req = 3'b001;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad = bad | (|cl_gnt) | ctrl_wr_enable | ctrl_rd_enable;
    end
    chk("busy_stall", 64'(bad), 0);
    push(0, 0, '0, '0, 1'b0);
    push(1, 0, 24'h77, 16'h1234, 1'b0);
    ctrl_busy = 1'b0;
    @(negedge clk);
    chk("gnt_after_busy", 64'(cl_gnt), 64'b001);
    cl_req = '0;
    wait_done();
    cl_we = '0;
    rd_lat = 0;
    push(0, 1, '0, '0, 1'b0);
    push(2, 1, '0, '0, 1'b1);
    cl_req = 3'b010;
    wait_gnts(1, cyc);
    cl_req = '0;
    wait_done();
    chk("tmo_en_len", 64'(last_run), TMO);
    chk("tmo_flag", 64'(arb_timeout), 1);
    chk("rdata_after_tmo", 64'(cl_rdata), 0);
    cl_we = 3'b100;
    cl_wdata[2*DW +: DW] = 16'h0bee;
    push(0, 2, '0, '0, 1'b0);
    push(1, 0, 24'h5, 16'h0bee, 1'b0);
    cl_req = 3'b100;
    wait_gnts(1, cyc);
    cl_req = '0;
    wait_done();
    chk("tmo_sticky", 64'(arb_timeout), 1);
    cl_we = '0;
    push(0, 0, '0, '0, 1'b0);
    cl_req = 3'b001;
    wait_gnts(1, cyc);
    cl_req = '0;
    repeat (3) @(negedge clk);
    chk("mid_read_en", 64'(ctrl_rd_enable), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_gnt", 64'(cl_gnt), 0);
    chk("mrst_rvalid", 64'(cl_rvalid), 0);
    chk("mrst_rd_en", 64'(ctrl_rd_enable), 0);
    chk("mrst_wr_en", 64'(ctrl_wr_enable), 0);
    chk("mrst_rd_addr", 64'(ctrl_rd_addr), 0);
    chk("mrst_timeout", 64'(arb_timeout), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    cl_we = '1;
    push(0, 0, '0, '0, 1'b0);
    push(1, 0, 24'h77, 16'h1234, 1'b0);
    cl_req = '1;
    wait_gnts(1, cyc);
    cl_req = '0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
